// File: rtl/sprite_palette_engine_pkg.sv
// sprite_palette_engine_pkg: fade states, colour type, default palette and fade arithmetic
package sprite_palette_engine_pkg;
  typedef enum logic [1:0] {IDLE, FADE_OUT, BLACK, FADE_IN} fade_state_t;
  typedef logic [11:0] rgb_t;
  localparam rgb_t DEFAULT_PAL [16] = '{
    12'h000, 12'h9C4, 12'h0F0, 12'hB52, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F,
    12'h888, 12'hF80, 12'h840, 12'h4F4, 12'h44F, 12'hF44, 12'hCCC, 12'hFFF
  };
  function automatic logic [3:0] fade_ch(input logic [3:0] c, input logic [3:0] amt);
    logic signed [4:0] d;
    d = $signed({1'b0, c}) - $signed({1'b0, amt});
    return d[4] ? 4'h0 : d[3:0];
  endfunction
  function automatic rgb_t fade_rgb(input rgb_t c, input logic [3:0] amt);
    return {fade_ch(c[11:8], amt), fade_ch(c[7:4], amt), fade_ch(c[3:0], amt)};
  endfunction
endpackage

// File: rtl/sprite_palette_engine_if.sv
// sprite_palette_engine_if: pixel lookup, palette write and registered colour bus
interface sprite_palette_engine_if #(
  parameter int IDX_W = 4,
  parameter int PAL_W = 2
);
  logic             pix_valid_in;
  logic [PAL_W-1:0] pal_sel;
  logic [IDX_W-1:0] index;
  logic             wr_en;
  logic [PAL_W-1:0] wr_pal;
  logic [IDX_W-1:0] wr_idx;
  logic [11:0]      wr_rgb;
  logic [3:0]       red;
  logic [3:0]       green;
  logic [3:0]       blue;
  logic             pix_valid_out;
  logic             transparent;
  modport master (
    output pix_valid_in, pal_sel, index, wr_en, wr_pal, wr_idx, wr_rgb,
    input  red, green, blue, pix_valid_out, transparent
  );
  modport slave (
    input  pix_valid_in, pal_sel, index, wr_en, wr_pal, wr_idx, wr_rgb,
    output red, green, blue, pix_valid_out, transparent
  );
endinterface

// File: rtl/palette_fade_ctrl.sv
// palette_fade_ctrl: frame-stepped fade FSM and damage-flash counter
module palette_fade_ctrl
  import sprite_palette_engine_pkg::*;
#(
  parameter int FLASH_FRAMES = 16
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       fade_start,
  input  logic       fade_dir,
  input  logic       flash_start,
  output logic [3:0] fade_amt,
  output logic       flash_on,
  output logic       fade_busy,
  output logic       fade_done
);
  localparam int CNT_W = $clog2(FLASH_FRAMES + 1);
  fade_state_t      state;
  logic [CNT_W-1:0] flash_cnt;
  assign fade_busy = state != IDLE;
  assign flash_on  = flash_cnt != '0 && flash_cnt[0];
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= IDLE;
      fade_amt  <= 4'h0;
      fade_done <= 1'b0;
      flash_cnt <= '0;
    end else begin
      fade_done <= 1'b0;
      flash_cnt <= flash_start ? CNT_W'(FLASH_FRAMES) :
                   (frame_tick && flash_cnt != '0) ? flash_cnt - 1'b1 : flash_cnt;
      // a start takes priority over a coincident tick; stepping waits for the next tick
      case (state)
        IDLE: if (fade_start) begin
          state    <= fade_dir ? FADE_IN : FADE_OUT;
          fade_amt <= fade_dir ? 4'hF : 4'h0;
        end
        BLACK: if (fade_start && fade_dir) state <= FADE_IN;
        FADE_OUT: if (frame_tick) begin
          fade_amt <= fade_amt + 4'd1;
          if (fade_amt == 4'hE) begin
            state     <= BLACK;
            fade_done <= 1'b1;
          end
        end
        FADE_IN: if (frame_tick) begin
          fade_amt <= fade_amt - 4'd1;
          if (fade_amt == 4'h1) begin
            state     <= IDLE;
            fade_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/sprite_palette_engine.sv
// sprite_palette_engine: banked palette lookup with fade and flash effects
module sprite_palette_engine
  import sprite_palette_engine_pkg::*;
#(
  parameter int IDX_W        = 4,
  parameter int NUM_PAL      = 4,
  parameter int FLASH_FRAMES = 16,
  parameter int TRANSP_EN    = 1
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  sprite_palette_engine_if.slave  bus,
  input  logic                    frame_tick,
  input  logic                    fade_start,
  input  logic                    fade_dir,
  input  logic                    flash_start,
  output logic                    fade_busy,
  output logic                    fade_done
);
  localparam int PAL_W   = NUM_PAL > 1 ? $clog2(NUM_PAL) : 1;
  localparam int ENTRIES = 2 ** IDX_W;
  rgb_t             mem [NUM_PAL][ENTRIES];
  logic [3:0]       fade_amt;
  logic             flash_on;
  logic             bad;
  logic             tr;
  logic [PAL_W-1:0] rd_pal;
  rgb_t             pix;
  palette_fade_ctrl #(.FLASH_FRAMES(FLASH_FRAMES)) u_fx (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .fade_start(fade_start),
    .fade_dir(fade_dir), .flash_start(flash_start), .fade_amt(fade_amt),
    .flash_on(flash_on), .fade_busy(fade_busy), .fade_done(fade_done)
  );
  always_comb begin
    bad    = int'(bus.pal_sel) >= NUM_PAL;
    rd_pal = bad ? '0 : PAL_W'(bus.pal_sel);
    tr     = bad || (TRANSP_EN != 0 && bus.index == '0);
    pix    = mem[rd_pal][bus.index];
  end
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int p = 0; p < NUM_PAL; p++)
        for (int i = 0; i < ENTRIES; i++)
          mem[p][i] <= (p == 0 && i < 16) ? DEFAULT_PAL[i[3:0]] : '0;
      {bus.red, bus.green, bus.blue} <= '0;
      bus.pix_valid_out <= 1'b0;
      bus.transparent   <= 1'b0;
    end else begin
      if (bus.wr_en && int'(bus.wr_pal) < NUM_PAL) mem[bus.wr_pal][bus.wr_idx] <= bus.wr_rgb;
      bus.pix_valid_out <= bus.pix_valid_in;
      bus.transparent   <= bus.pix_valid_in && tr;
      {bus.red, bus.green, bus.blue} <= (!bus.pix_valid_in || tr) ? 12'h000 :
                                        flash_on ? 12'hFFF : fade_rgb(pix, fade_amt);
    end
  end
endmodule

// File: doc/sprite_palette_engine.md
SPRITE_PALETTE_ENGINE -- requirements
Module: sprite_palette_engine

Interface
REQ-001 SHALL have parameter IDX_W, default 4: palette index width; entries per palette = 2**IDX_W.
REQ-002 SHALL have parameter NUM_PAL, default 4: number of selectable palettes (banks); PAL_W = max(1, clog2(NUM_PAL)).
REQ-003 SHALL have parameter FLASH_FRAMES, default 16: length of a damage flash in frames.
REQ-004 SHALL have parameter TRANSP_EN, default 1: when 1, index 0 of every bank is transparent.
REQ-005 Clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 Reset_n  in  1  synchronous, active-low reset.
REQ-007 pix_valid_in  in  1  index and pal_sel are valid this cycle.
REQ-008 pal_sel  in  PAL_W  bank to look up.
REQ-009 index  in  IDX_W  colour index within the bank.
REQ-010 wr_en  in  1  palette write strobe.
REQ-011 wr_pal  in  PAL_W  bank to write.
REQ-012 wr_idx  in  IDX_W  entry to write.
REQ-013 wr_rgb  in  12  {R,G,B}, 4 bits each.
REQ-014 frame_tick  in  1  one-cycle pulse per frame (vsync edge).
REQ-015 fade_start  in  1  one-cycle pulse that starts a fade.
REQ-016 fade_dir  in  1  0 = fade to black, 1 = fade from black; sampled with fade_start.
REQ-017 flash_start  in  1  one-cycle pulse that starts a damage flash.
REQ-018 red, green, blue  out  4 each  registered colour.
REQ-019 pix_valid_out  out  1  pix_valid_in delayed by 1 cycle.
REQ-020 transparent  out  1  pixel is transparent; qualified by pix_valid_out.
REQ-021 fade_busy  out  1  fade FSM is not IDLE.
REQ-022 fade_done  out  1  one-cycle pulse when a fade completes.

Function
REQ-023 Lookup latency SHALL be exactly 1 cycle: outputs at cycle N+1 reflect inputs, bank contents and effect state at cycle N.
REQ-024 When pix_valid_in=0, colour outputs SHALL be 0 the next cycle and transparent SHALL be 0.
REQ-025 A write SHALL update the entry at the clock edge; a lookup of the same entry in the same cycle SHALL return the old value.
REQ-026 Writes with wr_pal >= NUM_PAL SHALL be ignored; lookups with pal_sel >= NUM_PAL SHALL output 0 with transparent=1.
REQ-027 transparent SHALL be 1 iff TRANSP_EN=1 and index=0; a transparent pixel's colour SHALL be 0, and no effect SHALL apply to it.
REQ-028 Fade FSM states SHALL be IDLE, FADE_OUT, BLACK and FADE_IN, with 4-bit fade_amt.
REQ-029 In IDLE, fade_start with fade_dir=0 SHALL go to FADE_OUT with fade_amt=0; with fade_dir=1 it SHALL go to FADE_IN with fade_amt=15.
REQ-030 In BLACK, fade_start with fade_dir=1 SHALL go to FADE_IN; fade_start with fade_dir=0 SHALL be ignored.
REQ-031 In FADE_OUT, each frame_tick SHALL increment fade_amt; the tick that reaches 15 SHALL go to BLACK and pulse fade_done.
REQ-032 In FADE_IN, each frame_tick SHALL decrement fade_amt; the tick that reaches 0 SHALL go to IDLE and pulse fade_done.
REQ-033 fade_start in FADE_OUT or FADE_IN SHALL be ignored.
REQ-034 If fade_start and frame_tick occur in the same cycle, the FSM SHALL start and SHALL NOT step; stepping begins at the next frame_tick.
REQ-035 Each colour channel SHALL be max(c - fade_amt, 0) per channel, using 5-bit signed intermediate arithmetic and no wrap.
REQ-036 flash_start SHALL load flash_cnt with FLASH_FRAMES, and SHALL restart the flash if one is active; each frame_tick while flash_cnt>0 SHALL decrement it.
REQ-037 While flash_cnt>0 and flash_cnt[0]=1, non-transparent pixels SHALL output 4'hF on all channels; flash SHALL override fade.
REQ-038 Fade and flash SHALL run independently; simultaneous starts SHALL both take effect.

Reset
REQ-039 Reset_n=0 at an edge SHALL clear all outputs to 0, set the FSM to IDLE, and clear fade_amt and flash_cnt to 0.
REQ-040 Reset SHALL load bank 0 from DEFAULT_PAL and zero all other banks; reset mid-fade or mid-flash SHALL abort with no fade_done.

Structure
REQ-041 A shared package SHALL hold the fade state enum, the 12-bit rgb typedef and the 16-entry DEFAULT_PAL constant.
REQ-042 Storage SHALL be a flop array; one sub-module, palette_fade_ctrl, SHALL contain the fade FSM and flash counter.

Verification
REQ-043 Default lookup: after reset, pal_sel=0 and index=3 -> next cycle {R,G,B}={B,5,2}; index=0 -> transparent=1 and colour 0.
REQ-044 Write/read collision: write bank 1 idx 5 = 12'h123 while reading the same entry -> old value 000; the following read -> 1,2,3.
REQ-045 Fade-out: fade_start with dir=0, then 3 frame_ticks on a pixel of {9,C,4} -> {6,9,1}; after 15 ticks -> {0,0,0}, one fade_done, state BLACK.
REQ-046 Fade-in from BLACK with fade_start and frame_tick in the same cycle -> fade_amt stays 15 that cycle; 15 further ticks -> IDLE, fade_done.
REQ-047 Flash with FLASH_FRAMES=4 -> white output on frames with cnt=3 and 1, normal otherwise; a transparent pixel is never white.
REQ-048 Reset asserted mid-FADE_OUT with fade_amt=7 -> all outputs 0, fade_busy=0, fade_done never pulses.
